// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: DMA channel request resolver with grant lock.
// Define DMA_DREQ_SYNC_EN to add a 2-flop DREQ synchroniser.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqActiveLow,
  input  logic              controllerDisable,
  input  logic              rotatingPriority,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              writeRequest,
  input  logic [CH_W:0]     requestData,
  input  logic              grantAck,
  input  logic              channelDone,
  input  logic              tcReached,
  output logic              hrqReq,
  output logic              grantValid,
  output logic [CH_W-1:0]   grantChannel,
  output logic [NUM_CH-1:0] grantOneHot,
  output logic [NUM_CH-1:0] pendingStatus
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    GRANTED
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] soft_req_q, soft_req_d;
  logic [CH_W-1:0]   prio_q, prio_d;
  logic              hrq_q, hrq_d;
  logic              gv_q, gv_d;
  logic [CH_W-1:0]   gch_q, gch_d;
  logic [NUM_CH-1:0] goh_q, goh_d;
  logic [NUM_CH-1:0] pend_q, pend_d;

  logic [NUM_CH-1:0] dreq_raw;
  logic [NUM_CH-1:0] eff_req;
  logic [CH_W-1:0]   prio_eff;
  logic [CH_W-1:0]   win;
  logic [CH_W-1:0]   idx;
  logic              win_found;

`ifdef DMA_DREQ_SYNC_EN
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;

  // Two-flop DREQ synchroniser, reset to the inactive level
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sync1_q <= {NUM_CH{dreqActiveLow}};
      sync2_q <= {NUM_CH{dreqActiveLow}};
    end else begin
      sync1_q <= DREQ;
      sync2_q <= sync1_q;
    end
  end

  assign dreq_raw = sync2_q;
`else
  assign dreq_raw = DREQ;
`endif

  // Effective request: polarity-corrected DREQ or soft request, unmasked
  always_comb begin
    eff_req = ((dreq_raw ^ {NUM_CH{dreqActiveLow}})
              | soft_req_q) & ~maskReg;
    if (controllerDisable) begin
      eff_req = '0;
    end
  end

  assign prio_eff = rotatingPriority ? prio_q : '0;

  // Winner: first set request scanning upward from the priority pointer
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = prio_eff + CH_W'(i);
      if (!win_found && eff_req[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  // Next state, soft request, priority pointer and registered outputs
  always_comb begin
    state_d    = state_q;
    soft_req_d = soft_req_q;
    prio_d     = prio_q;
    gch_d      = gch_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = REQUEST;
          gch_d   = win;
        end
      end
      REQUEST: begin
        if (!win_found) begin
          state_d = IDLE;
        end else begin
          gch_d = win;
          if (grantAck) begin
            state_d = GRANTED;
          end
        end
      end
      GRANTED: begin
        if (channelDone) begin
          state_d = IDLE;
          if (rotatingPriority) begin
            prio_d = gch_q + CH_W'(1);
          end
          if (tcReached) begin
            soft_req_d[gch_q] = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rotatingPriority) begin
      prio_d = '0;
    end
    // A software write overrides a same-cycle TC clear
    if (writeRequest) begin
      soft_req_d[requestData[CH_W-1:0]] = requestData[CH_W];
    end
    hrq_d = (state_q != IDLE) && (state_d != IDLE);
    gv_d  = (state_d == GRANTED);
    goh_d = '0;
    if (gv_d) begin
      goh_d[gch_d] = 1'b1;
    end
    pend_d = eff_req;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      soft_req_q <= '0;
      prio_q     <= '0;
      hrq_q      <= 1'b0;
      gv_q       <= 1'b0;
      gch_q      <= '0;
      goh_q      <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      soft_req_q <= soft_req_d;
      prio_q     <= prio_d;
      hrq_q      <= hrq_d;
      gv_q       <= gv_d;
      gch_q      <= gch_d;
      goh_q      <= goh_d;
      pend_q     <= pend_d;
    end
  end

  assign hrqReq        = hrq_q;
  assign grantValid    = gv_q;
  assign grantChannel  = gch_q;
  assign grantOneHot   = goh_q;
  assign pendingStatus = pend_q;

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Channel request resolver for the DMA controller, directly upstream of timing and control.
- Combines hardware DREQ lines, software request bits and the mask register into one winning channel, using fixed or rotating priority.
- Raises a hold request toward timing and control.
- Locks the granted channel for the whole service; releases it when timing and control signals channel completion.

Parameters:
- NUM_CH, 4, number of DMA channels; power of two, 2..8.
- CH_W, $clog2(NUM_CH), width of the channel index.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- DREQ  in  NUM_CH  raw channel request lines.
- dreqActiveLow  in  1  command-register DREQ sense: 1 = DREQ active low.
- controllerDisable  in  1  command-register disable; forces the effective request vector to 0.
- rotatingPriority  in  1  command-register priority select: 1 = rotating, 0 = fixed (ch0 highest).
- maskReg  in  NUM_CH  per-channel mask; 1 = masked.
- writeRequest  in  1  one-cycle software request-register write strobe.
- requestData  in  CH_W+1  request-register write data: [CH_W] = set(1)/clear(0), [CH_W-1:0] = channel.
- grantAck  in  1  one-cycle pulse from timing and control: HLDA seen, lock the winner.
- channelDone  in  1  one-cycle pulse from timing and control: service ended (EOP or TC).
- tcReached  in  1  qualifies channelDone: terminal count reached.
- hrqReq  out  1  hold request to timing and control.
- grantValid  out  1  granted channel locked.
- grantChannel  out  CH_W  locked or current winning channel.
- grantOneHot  out  NUM_CH  decode of grantChannel while grantValid, else 0 (DACK select).
- pendingStatus  out  NUM_CH  registered effective request vector (status bits 7:4).

Behaviour:
- Effective request, combinational: effReq = ((DREQ ^ {NUM_CH{dreqActiveLow}}) | softReq) & ~maskReg. Forced to 0 while controllerDisable = 1.
- Priority pointer prio (CH_W bits) names the highest-priority channel.
  - Winner = first set bit of effReq, scanning prio, prio+1, … modulo NUM_CH.
  - prio is held at 0 whenever rotatingPriority = 0.
- States: IDLE, REQUEST, GRANTED; all outputs registered.
- IDLE:
  - effReq != 0 → REQUEST; hrqReq = 1 on the following cycle.
  - grantAck and channelDone are ignored.
- REQUEST:
  - The winner is re-evaluated every cycle; grantChannel tracks it, so a higher-priority arrival pre-empts before acknowledgment.
  - effReq == 0 → IDLE; hrqReq = 0 next cycle.
  - grantAck → GRANTED; grantChannel frozen at that cycle's winner; grantValid = 1 next cycle.
  - channelDone in the same cycle as grantAck is ignored.
- GRANTED:
  - Grant held regardless of changes in DREQ, mask or softReq.
  - channelDone → IDLE; hrqReq = 0 and grantValid = 0 next cycle.
  - If rotatingPriority = 1, prio ← grantChannel + 1 mod NUM_CH, so the serviced channel becomes lowest priority.
  - If tcReached = 1, softReq[grantChannel] is cleared.
- softReq register:
  - writeRequest sets or clears bit requestData[CH_W-1:0] per requestData[CH_W].
  - A simultaneous write and TC clear on the same bit: the write wins.
- pendingStatus ← effReq every cycle.
- Latency:
  - DREQ assert → hrqReq = 1: 2 edges (IDLE→REQUEST transition, then output register).
  - grantAck → grantValid: 1 edge.
  - channelDone → hrqReq/grantValid low: 1 edge.
- Reset (RESET = 0 at a rising edge), including mid-grant, takes effect at that edge:
  - State IDLE, hrqReq 0, grantValid 0, grantChannel 0, grantOneHot 0, pendingStatus 0, softReq 0, prio 0.

Optional Feature:
- DMA_DREQ_SYNC_EN defined: DREQ passes a 2-flop synchroniser before polarity correction. DREQ→hrqReq latency becomes 4 edges. Synchroniser flops reset to the inactive level (all 1 when dreqActiveLow = 1, else 0).
- Undefined: DREQ is used directly; latency is 2 edges.

Test Plan:
- Reset then DREQ=4'b0001, mask=0, fixed priority → hrqReq=1 two edges later, grantChannel=0; grantAck → grantValid=1, grantOneHot=4'b0001; channelDone → hrqReq=0, grantValid=0 next edge.
- Fixed priority, DREQ=4'b1010 → grantChannel=1; after channelDone with DREQ still 4'b1010 → grantChannel=1 again.
- Rotating priority, DREQ=4'b0011 held, three grant/done cycles → grant order 0,1,0; prio after first done = 1.
- Masking and polarity: maskReg=4'b0001, DREQ=4'b0001 → hrqReq stays 0; dreqActiveLow=1, DREQ=4'b1011 → channel 2 wins; controllerDisable=1 → hrqReq=0, pendingStatus=0.
- Software request: writeRequest, requestData=3'b110 → softReq=4'b0100, channel 2 granted; channelDone with tcReached=1 → softReq=0; same-cycle set write → bit stays 1.
- Pre-emption and reset: in REQUEST with grantChannel=3, DREQ[0] asserts → grantChannel=0 next edge; RESET=0 while GRANTED → all outputs 0 at that edge, state IDLE.
